// File: rtl/bf_uart_tx.sv
// Byte FIFO plus 8N1 serialiser carrying the core's '.' output to the host UART pin.
// Latency: a byte written on edge N into an idle, empty block is popped on N+1; tx falls after N+2.
// Backpressure: out_ready = FIFO not full; a refused offer sets the sticky overflow flag.
module bf_uart_tx #(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        out_valid,
  input  logic [7:0]                  out_data,
  output logic                        out_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          push;
  logic          pop;
  logic          baud_last;

  assign out_ready  = (count != FULL);
  assign push       = out_valid && out_ready;
  assign baud_last  = (baud_cnt == BAUD_MAX);
  // Pop either from idle or on the final stop-bit cycle, so frames run back to back.
  assign pop        = (count != '0) && ((state == S_IDLE) || ((state == S_STOP) && baud_last));
  assign busy       = (state != S_IDLE) || (count != '0);
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= out_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
      if (out_valid && !out_ready) overflow <= 1'b1;
    end
  end

  // tx is registered from the current state, so the line lags the state by one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shreg    <= mem[rd_ptr];
            baud_cnt <= '0;
            state    <= S_START;
          end
        end
        S_START: begin
          tx <= 1'b0;
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        S_DATA: begin
          tx <= shreg[bit_idx];
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) state <= S_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        S_STOP: begin
          tx <= 1'b1;
          if (baud_last) begin
            baud_cnt <= '0;
            if (pop) begin
              shreg <= mem[rd_ptr];
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
